// File: rtl/jdec_pkg.sv
// Shared types and helpers for the Johnson phase decoder: FSM state encoding,
// phase-width helper and the modular phase successor.
package jdec_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    CHECK = 2'd1,
    LOCK  = 2'd2
  } jdec_state_t;

  function automatic int calc_pw(input int width);
    return $clog2(2 * width);
  endfunction

  function automatic int next_phase(input int phase, input int width);
    return (phase + 1) % (2 * width);
  endfunction

endpackage

// File: rtl/johnson_phase_decoder_if.sv
// Sample/result bundle between a Johnson code source and johnson_phase_decoder.
// VALID qualifies JC for one cycle; there is no backpressure, every VALID sample is consumed.
interface johnson_phase_decoder_if
  import jdec_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = 8
);
    localparam int PW = calc_pw(WIDTH);

    logic                 VALID;
    logic [WIDTH-1:0]     JC;
    logic [PW-1:0]        PHASE;
    logic [2*WIDTH-1:0]   ONEHOT;
    logic                 LEGAL;
    logic                 LOCKED;
    logic                 SEQ_ERR;
    logic [CW-1:0]        CYCLES;
    jdec_state_t          state;

    modport master (
        output VALID, JC,
        input  PHASE, ONEHOT, LEGAL, LOCKED, SEQ_ERR, CYCLES, state
    );

    modport slave (
        input  VALID, JC,
        output PHASE, ONEHOT, LEGAL, LOCKED, SEQ_ERR, CYCLES, state
    );

endinterface

// File: rtl/johnson_decode.sv
// Combinational Johnson code to phase index decoder; legal=0 for any code
// outside the 2*WIDTH-entry sequence.
module johnson_decode
  import jdec_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PW    = calc_pw(WIDTH)
) (
    input  logic [WIDTH-1:0] jc,
    output logic [PW-1:0]    phase,
    output logic             legal
);

    logic [WIDTH-1:0] pat;

    // Phase k<=N has the low k bits set; phase k>N has the low k-N bits clear.
    always_comb begin
        phase = '0;
        legal = 1'b0;
        pat   = '0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            for (int b = 0; b < WIDTH; b++) begin
                pat[b] = (k <= WIDTH) ? (b < k) : (b >= k - WIDTH);
            end
            if (jc == pat) begin
                phase = k[PW-1:0];
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Registered Johnson phase decoder with HUNT/CHECK/LOCK sequence tracking.
// Define JDEC_CYCLE_CNT_EN to build the completed-cycle counter; otherwise CYCLES is tied to 0.
module johnson_phase_decoder
  import jdec_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int CW       = 8
) (
    input  logic                   CLK,
    input  logic                   CLR,
    johnson_phase_decoder_if.slave bus
);

    localparam int              PW         = calc_pw(WIDTH);
    localparam int              CNTW       = $clog2(LOCK_CNT + 1);
    localparam logic [PW-1:0]   LAST_PHASE = PW'(2 * WIDTH - 1);

    logic [PW-1:0]      dec_phase;
    logic               dec_legal;
    logic [PW-1:0]      succ_phase;
    logic               good;
    logic [2*WIDTH-1:0] onehot_d;

    logic [PW-1:0]      phase_q;
    logic [2*WIDTH-1:0] onehot_q;
    logic               legal_q;
    logic               seq_err_q;
    logic               seq_err_d;
    jdec_state_t        state_q;
    jdec_state_t        state_d;
    logic [CNTW-1:0]    cnt_q;
    logic [CNTW-1:0]    cnt_d;

    johnson_decode #(
        .WIDTH (WIDTH),
        .PW    (PW)
    ) u_decode (
        .jc    (bus.JC),
        .phase (dec_phase),
        .legal (dec_legal)
    );

    // phase_q is the last legal phase, which is the step reference in CHECK and LOCK.
    assign succ_phase = PW'(next_phase(int'(phase_q), WIDTH));
    assign good       = dec_legal && (dec_phase == succ_phase);
    assign onehot_d   = {{(2*WIDTH-1){1'b0}}, 1'b1} << dec_phase;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seq_err_d = 1'b0;
        if (bus.VALID) begin
            case (state_q)
                HUNT: begin
                    if (dec_legal) begin
                        state_d = CHECK;
                        cnt_d   = '0;
                    end
                end
                CHECK: begin
                    if (!dec_legal) begin
                        state_d = HUNT;
                        cnt_d   = '0;
                    end else if (good) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == CNTW'(LOCK_CNT)) state_d = LOCK;
                    end else begin
                        cnt_d = '0;
                    end
                end
                LOCK: begin
                    if (!good) begin
                        seq_err_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = dec_legal ? CHECK : HUNT;
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q   <= HUNT;
            cnt_q     <= '0;
            seq_err_q <= 1'b0;
            phase_q   <= '0;
            onehot_q  <= '0;
            legal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seq_err_q <= seq_err_d;
            if (bus.VALID) begin
                legal_q <= dec_legal;
                if (dec_legal) begin
                    phase_q  <= dec_phase;
                    onehot_q <= onehot_d;
                end else begin
                    onehot_q <= '0;
                end
            end
        end
    end

`ifdef JDEC_CYCLE_CNT_EN
    logic          wrap;
    logic [CW-1:0] cycles_q;

    assign wrap = bus.VALID && (state_q == LOCK) && good && (phase_q == LAST_PHASE);

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            cycles_q <= '0;
        end else if (wrap) begin
            cycles_q <= cycles_q + 1'b1;
        end
    end

    assign bus.CYCLES = cycles_q;
`else
    assign bus.CYCLES = '0;
`endif

    assign bus.PHASE   = phase_q;
    assign bus.ONEHOT  = onehot_q;
    assign bus.LEGAL   = legal_q;
    assign bus.LOCKED  = (state_q == LOCK);
    assign bus.SEQ_ERR = seq_err_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed scoreboard bench for johnson_phase_decoder (WIDTH=4, LOCK_CNT=3, CW=8).
module tb_johnson_phase_decoder;
  import jdec_pkg::*;

  localparam int EW = 24;

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  logic [EW-1:0] exp_q[$];

  johnson_phase_decoder_if #(.WIDTH(4), .CW(8)) bus ();

  johnson_phase_decoder #(
    .WIDTH    (4),
    .LOCK_CNT (3),
    .CW       (8)
  ) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [EW-1:0] pack_act();
    return {bus.state, bus.PHASE, bus.ONEHOT, bus.LEGAL, bus.LOCKED, bus.SEQ_ERR, bus.CYCLES};
  endfunction

  function automatic logic [7:0] cyc_model(input int cy);
`ifdef JDEC_CYCLE_CNT_EN
    return 8'(cy);
`else
    return 8'(cy * 0);
`endif
  endfunction

  function automatic void report(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    $display("FAIL %s: got state=%0d phase=%0d onehot=%h legal=%b locked=%b seq_err=%b cycles=%0d; expected state=%0d phase=%0d onehot=%h legal=%b locked=%b seq_err=%b cycles=%0d",
             name, act[23:22], act[21:19], act[18:11], act[10], act[9], act[8], act[7:0],
             exp[23:22], exp[21:19], exp[18:11], exp[10], exp[9], exp[8], exp[7:0]);
  endfunction

  // driver: present one sample and push the state expected one edge later
  task automatic step(input logic v, input logic [3:0] jc, input int ph, input bit lg,
                      input bit lk, input bit se, input int cy, input jdec_state_t st);
    logic [7:0] oh;
    @(negedge clk);
    bus.VALID = v;
    bus.JC    = jc;
    oh = lg ? (8'd1 << ph) : 8'd0;
    exp_q.push_back({st, 3'(ph), oh, lg, lk, se, cyc_model(cy)});
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = pack_act();
      checks++;
      if (a !== e) begin
        errors++;
        report("sample", a, e);
      end
    end
  end

  task automatic check_zero(input string name);
    logic [EW-1:0] a;
    a = pack_act();
    checks++;
    if (a !== '0) begin
      errors++;
      report(name, a, '0);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    clr       = 1'b1;
    bus.VALID = 1'b0;
    bus.JC    = 4'b0000;

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.VALID = 1'($urandom_range(0, 1));
      bus.JC    = 4'($urandom_range(0, 15));
      #1;
      check_zero("reset_hold");
    end
    @(negedge clk);
    clr = 1'b0;
    bus.VALID = 1'b0;

    // lock acquisition
    step(1, 4'b0000, 0, 1, 0, 0, 0, CHECK);
    step(1, 4'b0001, 1, 1, 0, 0, 0, CHECK);
    step(1, 4'b0011, 2, 1, 0, 0, 0, CHECK);
    step(1, 4'b0111, 3, 1, 1, 0, 0, LOCK);
    // wrap, two laps
    step(1, 4'b1111, 4, 1, 1, 0, 0, LOCK);
    step(1, 4'b1110, 5, 1, 1, 0, 0, LOCK);
    step(1, 4'b1100, 6, 1, 1, 0, 0, LOCK);
    step(1, 4'b1000, 7, 1, 1, 0, 0, LOCK);
    step(1, 4'b0000, 0, 1, 1, 0, 1, LOCK);
    step(1, 4'b0001, 1, 1, 1, 0, 1, LOCK);
    step(1, 4'b0011, 2, 1, 1, 0, 1, LOCK);
    step(1, 4'b0111, 3, 1, 1, 0, 1, LOCK);
    step(1, 4'b1111, 4, 1, 1, 0, 1, LOCK);
    step(1, 4'b1110, 5, 1, 1, 0, 1, LOCK);
    step(1, 4'b1100, 6, 1, 1, 0, 1, LOCK);
    step(1, 4'b1000, 7, 1, 1, 0, 1, LOCK);
    step(1, 4'b0000, 0, 1, 1, 0, 2, LOCK);
    // VALID gaps with JC changing
    step(1, 4'b0001, 1, 1, 1, 0, 2, LOCK);
    step(0, 4'b0101, 1, 1, 1, 0, 2, LOCK);
    step(0, 4'b1111, 1, 1, 1, 0, 2, LOCK);
    step(0, 4'b0000, 1, 1, 1, 0, 2, LOCK);
    step(0, 4'b1000, 1, 1, 1, 0, 2, LOCK);
    step(0, 4'b0110, 1, 1, 1, 0, 2, LOCK);
    step(1, 4'b0011, 2, 1, 1, 0, 2, LOCK);
    // skipped step while locked
    step(1, 4'b1111, 4, 1, 0, 1, 2, CHECK);
    step(1, 4'b1110, 5, 1, 0, 0, 2, CHECK);
    step(1, 4'b1100, 6, 1, 0, 0, 2, CHECK);
    step(1, 4'b1000, 7, 1, 1, 0, 2, LOCK);
    // illegal code while locked, then a second illegal
    step(1, 4'b0101, 7, 0, 0, 1, 2, HUNT);
    step(1, 4'b0110, 7, 0, 0, 0, 2, HUNT);
    // restart, bad legal sample in CHECK re-seeds, wrap in CHECK does not count
    step(1, 4'b0000, 0, 1, 0, 0, 2, CHECK);
    step(1, 4'b0001, 1, 1, 0, 0, 2, CHECK);
    step(1, 4'b0011, 2, 1, 0, 0, 2, CHECK);
    step(1, 4'b1100, 6, 1, 0, 0, 2, CHECK);
    step(1, 4'b1000, 7, 1, 0, 0, 2, CHECK);
    step(1, 4'b0000, 0, 1, 0, 0, 2, CHECK);
    step(1, 4'b0001, 1, 1, 1, 0, 2, LOCK);

    // asynchronous clear between edges while locked
    @(negedge clk);
    bus.VALID = 1'b0;
    @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    check_zero("async_clr");
    @(negedge clk);
    clr = 1'b0;

    // first samples after clear are HUNT samples
    step(1, 4'b1010, 0, 0, 0, 0, 0, HUNT);
    step(1, 4'b0011, 2, 1, 0, 0, 0, CHECK);
    @(negedge clk);
    bus.VALID = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected samples left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
